// File: rtl/issue_scoreboard_pkg.sv
// issue_scoreboard_pkg: shared sizes and FSM encoding
// for the decode-to-execute issue scoreboard.
package issue_scoreboard_pkg;

  localparam int NUM_REGS      = 16;
  localparam int REG_ID_WIDTH  = 4;
  localparam int NUM_VREGS     = 64;
  localparam int VREG_ID_WIDTH = 6;
  localparam int CC_CNT_WIDTH  = 2;
  localparam int FLUSH_CYCLES  = 1;
  localparam int FLUSH_CNT_WIDTH =
    (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    SB_IDLE   = 2'd0,
    SB_FLUSH  = 2'd1,
    SB_HALTED = 2'd2
  } sb_state_e;

endpackage

// File: rtl/sb_busy_vector.sv
// sb_busy_vector: per-register in-flight bits; set beats clear
// on the same index; read ports for sources, dest and retire.
module sb_busy_vector #(
  parameter int DEPTH = 16,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [IW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_idx,
  input  logic [IW-1:0] rd0_idx,
  input  logic [IW-1:0] rd1_idx,
  output logic          rd0_busy,
  output logic          rd1_busy,
  output logic          set_busy,
  output logic          clr_busy
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign rd0_busy = busy_q[rd0_idx];
  assign rd1_busy = busy_q[rd1_idx];
  assign set_busy = busy_q[set_idx];
  assign clr_busy = busy_q[clr_idx];

endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: holds dependent instructions in decode,
// squashes wrong-path slots and parks the front end on HALT.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
(
  input  logic                     I_CLOCK,
  input  logic                     I_RESET,
  input  logic                     I_LOCK,
  input  logic                     I_GPUStallSignal,
  input  logic                     I_Issue_Valid,
  input  logic [REG_ID_WIDTH-1:0]  I_Src1RegIdx,
  input  logic [REG_ID_WIDTH-1:0]  I_Src2RegIdx,
  input  logic                     I_Src1Used,
  input  logic                     I_Src2Used,
  input  logic [VREG_ID_WIDTH-1:0] I_VSrc1RegIdx,
  input  logic [VREG_ID_WIDTH-1:0] I_VSrc2RegIdx,
  input  logic                     I_VSrc1Used,
  input  logic                     I_VSrc2Used,
  input  logic [REG_ID_WIDTH-1:0]  I_DestRegIdx,
  input  logic                     I_RegWEn,
  input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
  input  logic                     I_VRegWEn,
  input  logic                     I_CCWEn,
  input  logic                     I_CCRead,
  input  logic                     I_IsHalt,
  input  logic                     I_BranchTaken,
  input  logic                     I_WB_Valid,
  input  logic [REG_ID_WIDTH-1:0]  I_WB_DestRegIdx,
  input  logic                     I_WB_RegWEn,
  input  logic [VREG_ID_WIDTH-1:0] I_WB_DestVRegIdx,
  input  logic                     I_WB_VRegWEn,
  input  logic                     I_WB_CCWEn,
  output logic                     O_Issue,
  output logic                     O_Stall,
  output logic                     O_Flush,
  output logic                     O_Halted,
  output logic [CC_CNT_WIDTH-1:0]  O_CCPending,
  output logic                     O_Error
);

  localparam logic [CC_CNT_WIDTH-1:0] CC_MAX = '1;
  localparam logic [FLUSH_CNT_WIDTH-1:0] F_LOAD =
    FLUSH_CNT_WIDTH'(FLUSH_CYCLES);
  localparam logic [FLUSH_CNT_WIDTH-1:0] F_ONE =
    FLUSH_CNT_WIDTH'(1);

  sb_state_e                  state_q, state_d;
  logic [FLUSH_CNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic [CC_CNT_WIDTH-1:0]    cc_q, cc_d;
  logic                       err_q, err_d;

  logic s1_busy, s2_busy, d_busy, wb_busy;
  logic v1_busy, v2_busy, vd_busy, vwb_busy;
  logic s_set, s_clr, v_set, v_clr;
  logic hazard, gate, cc_inc, cc_dec;

  assign s_set = O_Issue & I_RegWEn;
  assign s_clr = I_WB_Valid & I_WB_RegWEn;
  assign v_set = O_Issue & I_VRegWEn;
  assign v_clr = I_WB_Valid & I_WB_VRegWEn;

  sb_busy_vector #(.DEPTH(NUM_REGS)) u_sreg (
    .clk      (I_CLOCK),
    .rst      (I_RESET),
    .set_en   (s_set),
    .set_idx  (I_DestRegIdx),
    .clr_en   (s_clr),
    .clr_idx  (I_WB_DestRegIdx),
    .rd0_idx  (I_Src1RegIdx),
    .rd1_idx  (I_Src2RegIdx),
    .rd0_busy (s1_busy),
    .rd1_busy (s2_busy),
    .set_busy (d_busy),
    .clr_busy (wb_busy)
  );

  sb_busy_vector #(.DEPTH(NUM_VREGS)) u_vreg (
    .clk      (I_CLOCK),
    .rst      (I_RESET),
    .set_en   (v_set),
    .set_idx  (I_DestVRegIdx),
    .clr_en   (v_clr),
    .clr_idx  (I_WB_DestVRegIdx),
    .rd0_idx  (I_VSrc1RegIdx),
    .rd1_idx  (I_VSrc2RegIdx),
    .rd0_busy (v1_busy),
    .rd1_busy (v2_busy),
    .set_busy (vd_busy),
    .clr_busy (vwb_busy)
  );

  // Registered state only: a retire this cycle is not bypassed.
  assign hazard = (I_Src1Used  & s1_busy)
                | (I_Src2Used  & s2_busy)
                | (I_VSrc1Used & v1_busy)
                | (I_VSrc2Used & v2_busy)
                | (I_RegWEn    & d_busy)
                | (I_VRegWEn   & vd_busy)
                | (I_CCRead    & (cc_q != '0))
                | (I_CCWEn     & (cc_q == CC_MAX));

  assign gate = I_LOCK & ~I_GPUStallSignal & ~I_BranchTaken;

  assign O_Issue = I_Issue_Valid & gate
                 & (state_q == SB_IDLE) & ~hazard;
  assign O_Flush = I_BranchTaken | (state_q == SB_FLUSH);
  assign O_Stall = I_Issue_Valid & I_LOCK
                 & ~O_Issue & ~O_Flush;

  assign cc_inc = O_Issue & I_CCWEn;
  assign cc_dec = I_WB_Valid & I_WB_CCWEn;

  always_comb begin
    cc_d = cc_q;
    if (cc_inc & ~cc_dec)
      cc_d = cc_q + 1'b1;
    else if (~cc_inc & cc_dec & (cc_q != '0))
      cc_d = cc_q - 1'b1;
  end

  always_comb begin
    err_d = err_q
          | (s_clr & ~wb_busy)
          | (v_clr & ~vwb_busy)
          | (cc_dec & (cc_q == '0));
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      SB_IDLE: begin
        if (I_BranchTaken) begin
          state_d = SB_FLUSH;
          fcnt_d  = F_LOAD;
        end else if (O_Issue & I_IsHalt) begin
          state_d = SB_HALTED;
        end
      end
      SB_FLUSH: begin
        if (I_BranchTaken) begin
          fcnt_d = F_LOAD;
        end else if (!I_GPUStallSignal) begin
          fcnt_d = fcnt_q - 1'b1;
          if (fcnt_q == F_ONE) state_d = SB_IDLE;
        end
      end
      SB_HALTED: begin
        state_d = SB_HALTED;
      end
      default: begin
        state_d = SB_IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q <= SB_IDLE;
      fcnt_q  <= '0;
      cc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      cc_q    <= cc_d;
      err_q   <= err_d;
    end
  end

  assign O_Halted    = (state_q == SB_HALTED);
  assign O_CCPending = cc_q;
  assign O_Error     = err_q;

endmodule
